int_sequencer: RTL and testbench

INT_SEQUENCER -- requirements
Module: int_sequencer

---
 rtl/int_sequencer.sv | 159 +++++++++++++++
 tb/tb_int_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt sequencer: freezes fetch, drains the pipe, injects a CALL, then steers PC to the vector.
// Optional build macro: INT_SEQUENCER_PENDING_EN (one-deep pending request captured during HANDLER).
module int_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [4:0]  CALL_OPCODE  = 5'b00101
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_interrupt,
    input  logic       i_stall,
    input  logic       i_flush,
    input  logic       i_rti_retire,
    output logic       o_fetch_hold,
    output logic       o_inject,
    output logic [4:0] o_op_code,
    output logic       o_interrupt,
    output logic       o_vector_sel,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_INJECT,
        S_VECTOR,
        S_HANDLER
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_count;
    logic [3:0] w_next_count;
    logic       r_int_prev;
    logic       r_armed;
    logic       w_edge;

    // r_armed stays low until the request line has been seen low after reset, so a level
    // held high across reset cannot masquerade as a fresh rising edge.
    assign w_edge = i_interrupt & ~r_int_prev & r_armed;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_int_prev <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_next_count;
            r_int_prev <= i_interrupt;
            r_armed    <= r_armed | ~i_interrupt;
        end
    end

`ifdef INT_SEQUENCER_PENDING_EN
    logic r_pending;
    logic w_next_pending;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_next_pending;
        end
    end
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
`ifdef INT_SEQUENCER_PENDING_EN
        w_next_pending = r_pending;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_next_state = S_DRAIN;
                    w_next_count = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                // A flush refills the pipe, so the drain window restarts from the top.
                if (i_flush) begin
                    w_next_count = DRAIN_INIT;
                end else if (!i_stall) begin
                    if (r_count == 4'd1) begin
                        w_next_state = S_INJECT;
                    end
                    w_next_count = r_count - 4'd1;
                end
            end
            S_INJECT: begin
                if (!i_stall) begin
                    w_next_state = S_VECTOR;
                end
            end
            S_VECTOR: begin
                if (!i_stall) begin
                    w_next_state = S_HANDLER;
                end
            end
            S_HANDLER: begin
`ifdef INT_SEQUENCER_PENDING_EN
                // An edge on the retire cycle still belongs to the handler and is taken here.
                if (i_rti_retire) begin
                    if (r_pending | w_edge) begin
                        w_next_state   = S_DRAIN;
                        w_next_count   = DRAIN_INIT;
                        w_next_pending = 1'b0;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (w_edge) begin
                    w_next_pending = 1'b1;
                end
`else
                if (i_rti_retire) begin
                    w_next_state = S_IDLE;
                end
`endif
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs decode the state register only; no input reaches an output combinationally.
    always_comb begin
        o_fetch_hold = 1'b0;
        o_inject     = 1'b0;
        o_op_code    = 5'd0;
        o_interrupt  = 1'b0;
        o_vector_sel = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_DRAIN: begin
                o_fetch_hold = 1'b1;
            end
            S_INJECT: begin
                o_fetch_hold = 1'b1;
                o_inject     = 1'b1;
                o_op_code    = CALL_OPCODE;
                o_interrupt  = 1'b1;
            end
            S_VECTOR: begin
                o_fetch_hold = 1'b1;
                o_vector_sel = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: a phase-level reference model compared every cycle,
// plus directed vectors with hand-computed timeline pins.
module tb_int_sequencer;

    localparam int DC = 2;
`ifdef INT_SEQUENCER_PENDING_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    localparam int P_IDLE    = 0;
    localparam int P_DRAIN   = 1;
    localparam int P_INJECT  = 2;
    localparam int P_VECTOR  = 3;
    localparam int P_HANDLER = 4;

    logic       clk;
    logic       rst_n;
    logic       intr;
    logic       stall;
    logic       flush;
    logic       rti;
    logic       fetch_hold;
    logic       inject;
    logic [4:0] op_code;
    logic       int_out;
    logic       vector_sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int_sequencer #(
        .DRAIN_CYCLES(DC),
        .CALL_OPCODE (5'b00101)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_interrupt (intr),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_rti_retire(rti),
        .o_fetch_hold(fetch_hold),
        .o_inject    (inject),
        .o_op_code   (op_code),
        .o_interrupt (int_out),
        .o_vector_sel(vector_sel),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks which phase of the interrupt sequence we are in and how many
    // drain cycles have been consumed, straight from the behavioural rules.
    int  m_phase = P_IDLE;
    int  m_used  = 0;
    int  m_queued = 0;
    bit  m_prev  = 1'b0;
    bit  m_armed = 1'b0;
    bit  model_valid = 1'b0;
    logic m_rise;

    assign m_rise = intr && !m_prev && m_armed;

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (!rst_n) begin
            m_phase  <= P_IDLE;
            m_used   <= 0;
            m_queued <= 0;
            m_prev   <= 1'b0;
            m_armed  <= 1'b0;
        end else begin
            m_prev  <= intr;
            m_armed <= m_armed || !intr;
            case (m_phase)
                P_IDLE: if (m_rise) begin
                    m_phase <= P_DRAIN;
                    m_used  <= 0;
                end
                P_DRAIN: if (flush) begin
                    m_used <= 0;
                end else if (!stall) begin
                    if (m_used + 1 == DC) m_phase <= P_INJECT;
                    m_used <= m_used + 1;
                end
                P_INJECT: if (!stall) m_phase <= P_VECTOR;
                P_VECTOR: if (!stall) m_phase <= P_HANDLER;
                P_HANDLER: begin
                    if (rti) begin
                        if (PEN && (m_queued > 0 || m_rise)) begin
                            m_phase <= P_DRAIN;
                            m_used  <= 0;
                        end else begin
                            m_phase <= P_IDLE;
                        end
                        m_queued <= 0;
                    end else if (PEN && m_rise) begin
                        m_queued <= 1;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_hold",   {7'd0, fetch_hold},
                  {7'd0, (m_phase == P_DRAIN || m_phase == P_INJECT || m_phase == P_VECTOR)});
            check("cmp_inject", {7'd0, inject},     {7'd0, (m_phase == P_INJECT)});
            check("cmp_opcode", {3'd0, op_code},    (m_phase == P_INJECT) ? 8'h05 : 8'h00);
            check("cmp_intout", {7'd0, int_out},    {7'd0, (m_phase == P_INJECT)});
            check("cmp_vector", {7'd0, vector_sel}, {7'd0, (m_phase == P_VECTOR)});
            check("cmp_busy",   {7'd0, busy},       {7'd0, (m_phase != P_IDLE)});
        end
    end

    // Holds the given inputs for one cycle; returns 1 time unit into the next cycle.
    task automatic cyc(input logic i, input logic s, input logic f, input logic r);
        intr  = i;
        stall = s;
        flush = f;
        rti   = r;
        @(posedge clk);
        #1;
    endtask

    // Low cycle, edge at cycle 0, then four plain cycles: lands in HANDLER at cycle 5.
    task automatic run_to_handler();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        intr  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rti   = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_hold", {7'd0, fetch_hold}, 8'd0);
        rst_n = 1'b1;

        // Basic sequence: edge at cycle 0.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("a_c1_hold", {7'd0, fetch_hold}, 8'd1);
        check("a_c1_inj",  {7'd0, inject}, 8'd0);
        cyc(1, 0, 0, 0);
        check("a_c2_hold", {7'd0, fetch_hold}, 8'd1);
        cyc(1, 0, 0, 0);
        check("a_c3_inj",  {7'd0, inject}, 8'd1);
        check("a_c3_op",   {3'd0, op_code}, 8'h05);
        check("a_c3_int",  {7'd0, int_out}, 8'd1);
        cyc(1, 0, 0, 0);
        check("a_c4_vec",  {7'd0, vector_sel}, 8'd1);
        check("a_c4_inj",  {7'd0, inject}, 8'd0);
        cyc(1, 0, 0, 0);
        check("a_c5_busy", {7'd0, busy}, 8'd1);
        check("a_c5_hold", {7'd0, fetch_hold}, 8'd0);
        cyc(1, 0, 0, 1);
        check("a_idle",    {7'd0, busy}, 8'd0);

        // Stall at cycles 3-4 stretches the injection.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("b_c3_inj", {7'd0, inject}, 8'd1);
        cyc(1, 1, 0, 0);
        check("b_c4_inj", {7'd0, inject}, 8'd1);
        cyc(1, 1, 0, 0);
        check("b_c5_inj", {7'd0, inject}, 8'd1);
        cyc(1, 0, 0, 0);
        check("b_c6_vec", {7'd0, vector_sel}, 8'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);

        // Flush at cycle 2, stray retire and edge during DRAIN are ignored.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        check("c_c2_hold", {7'd0, fetch_hold}, 8'd1);
        cyc(1, 0, 1, 0);
        check("c_c3_inj",  {7'd0, inject}, 8'd0);
        cyc(0, 0, 0, 0);
        check("c_c4_inj",  {7'd0, inject}, 8'd0);
        cyc(1, 0, 0, 0);
        check("c_c5_inj",  {7'd0, inject}, 8'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("c_c7_busy", {7'd0, busy}, 8'd1);
        cyc(0, 0, 0, 1);
        check("c_idle",    {7'd0, busy}, 8'd0);

        // Second edge in HANDLER, retire three cycles later.
        run_to_handler();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        if (PEN) begin
            check("d_redrain", {7'd0, fetch_hold}, 8'd1);
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
            check("d_reinject", {7'd0, inject}, 8'd1);
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 1);
        end else begin
            check("d_idle", {7'd0, busy}, 8'd0);
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
            check("d_noinj", {7'd0, busy}, 8'd0);
        end
        check("d_end", {7'd0, busy}, 8'd0);

        // Edge coincident with retire counts as a HANDLER arrival.
        run_to_handler();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        check("g_after", {7'd0, fetch_hold}, PEN ? 8'd1 : 8'd0);
        if (PEN) begin
            for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 1);
        end
        check("g_end", {7'd0, busy}, 8'd0);

        // Reset during INJECT, then a level held high must not retrigger.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("f_c3_inj", {7'd0, inject}, 8'd1);
        rst_n = 1'b0;
        cyc(1, 0, 0, 0);
        check("f_rst_busy", {7'd0, busy}, 8'd0);
        check("f_rst_inj",  {7'd0, inject}, 8'd0);
        check("f_rst_op",   {3'd0, op_code}, 8'd0);
        check("f_rst_int",  {7'd0, int_out}, 8'd0);
        check("f_rst_hold", {7'd0, fetch_hold}, 8'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0);
            check("f_held_high", {7'd0, busy}, 8'd0);
        end
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("f_rearm", {7'd0, fetch_hold}, 8'd1);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("f_end", {7'd0, busy}, 8'd0);

        cyc(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
